spi_gain_programmer: RTL and testbench

- Parametrised SPI master that programmes the front-end programmable-gain amplifier (two 4-bit channel codes per 8-bit word by default).
- Generates its own SCK, chip-select and MOSI, and captures the previous gain word that the amplifier shifts back on MISO.
- Optionally loads a default gain automatically after reset.
- Sits between the scope control/register logic and the amplifier pins, beside the ADC capture path.

---
 rtl/spi_gain_pkg.sv | 22 ++
 rtl/spi_tick_gen.sv | 36 +++
 rtl/spi_gain_programmer.sv | 157 +++++++++++++++
 tb/tb_spi_gain_programmer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_gain_pkg.sv
// Shared types and constants for the PGA gain programmer.
// The bench reuses xfer_cycles() to derive chip-select timing.
package spi_gain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int              DEF_DATA_W = 8;
    localparam int              DEF_DIV    = 2;
    localparam logic [7:0]      DEF_GAIN   = 8'h11;

    // Number of clk cycles spi_cs_n stays low for one transfer.
    function automatic int xfer_cycles(input int data_w, input int div);
        return (2 * data_w + 2) * div;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Free-running DIV-cycle divider; tick is high on the last cycle of each
// period, and clear restarts the period so every state gets a full DIV cycles.
module spi_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_gain_programmer.sv
// SPI mode-0 master that writes a gain word to the front-end PGA and
// captures the previous word the amplifier shifts back on MISO.
module spi_gain_programmer
    import spi_gain_pkg::*;
#(
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                DIV          = DEF_DIV,
    parameter logic [DATA_W-1:0] DEFAULT_GAIN = DATA_W'(DEF_GAIN),
    parameter bit                AUTO_LOAD    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    // start/ready: a request is taken on a rising clk edge with start && ready;
    // tx_data is sampled on that edge only and a start seen while busy is dropped.
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    input  logic              spi_miso,
    output state_t            dbg_state
);
    localparam int            BW       = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

    state_t            state_q,   state_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0] rx_sh_q,   rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              sck_q,     sck_d;
    logic              mosi_q,    mosi_d;
    logic              cs_n_q,    cs_n_d;
    logic              ready_q,   ready_d;
    logic              done_q,    done_d;
    logic              auto_q,    auto_d;
    logic              tick;
    logic              tick_clear;

    assign tick_clear = (state_q == IDLE) || (state_d != state_q);

    spi_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        auto_d    = auto_q;
        case (state_q)
            IDLE: begin
                // The pending auto-load behaves exactly like an accepted start.
                if (auto_q || (start && ready_q)) begin
                    shift_d   = auto_q ? DEFAULT_GAIN : tx_data;
                    mosi_d    = shift_d[DATA_W-1];
                    cs_n_d    = 1'b0;
                    ready_d   = 1'b0;
                    auto_d    = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sck_d     = 1'b1;
                    rx_sh_d   = {rx_sh_q[DATA_W-2:0], spi_miso};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_cnt_q != LAST_BIT) begin
                            shift_d = shift_q << 1;
                            mosi_d  = shift_q[DATA_W-2];
                        end
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        sck_d     = 1'b1;
                        rx_sh_d   = {rx_sh_q[DATA_W-2:0], spi_miso};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    mosi_d    = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            ready_q   <= !AUTO_LOAD;
            done_q    <= 1'b0;
            auto_q    <= AUTO_LOAD;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            auto_q    <= auto_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs_n  = cs_n_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_gain_programmer.sv
// Directed bench for three configurations of the gain programmer, each with a
// small SPI slave model that records MOSI and replays a readback word on MISO.
`timescale 1ns/1ps
module tb_spi_gain_programmer;
    import spi_gain_pkg::*;

    localparam int LIMIT = 500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // dut_a: auto-load, 8 bit, DIV 2
    logic        rst_a = 1'b0, start_a = 1'b0, miso_a = 1'b0;
    logic [7:0]  tx_a = 8'h00;
    logic        ready_a, done_a, sck_a, mosi_a, cs_a;
    logic [7:0]  rx_a;
    state_t      dbg_a;

    // dut_b: host-started, 8 bit, DIV 2
    logic        rst_b = 1'b0, start_b = 1'b0, miso_b = 1'b0;
    logic [7:0]  tx_b = 8'h00;
    logic        ready_b, done_b, sck_b, mosi_b, cs_b;
    logic [7:0]  rx_b;
    state_t      dbg_b;

    // dut_c: host-started, 16 bit, DIV 1
    logic        rst_c = 1'b0, start_c = 1'b0, miso_c = 1'b0;
    logic [15:0] tx_c = 16'h0000;
    logic        ready_c, done_c, sck_c, mosi_c, cs_c;
    logic [15:0] rx_c;
    state_t      dbg_c;

    spi_gain_programmer #(.DATA_W(8), .DIV(2), .DEFAULT_GAIN(8'h11), .AUTO_LOAD(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .tx_data(tx_a), .ready(ready_a),
        .done(done_a), .rx_data(rx_a), .spi_sck(sck_a), .spi_mosi(mosi_a),
        .spi_cs_n(cs_a), .spi_miso(miso_a), .dbg_state(dbg_a));

    spi_gain_programmer #(.DATA_W(8), .DIV(2), .DEFAULT_GAIN(8'h11), .AUTO_LOAD(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .tx_data(tx_b), .ready(ready_b),
        .done(done_b), .rx_data(rx_b), .spi_sck(sck_b), .spi_mosi(mosi_b),
        .spi_cs_n(cs_b), .spi_miso(miso_b), .dbg_state(dbg_b));

    spi_gain_programmer #(.DATA_W(16), .DIV(1), .DEFAULT_GAIN(16'h0011), .AUTO_LOAD(1'b0)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .tx_data(tx_c), .ready(ready_c),
        .done(done_c), .rx_data(rx_c), .spi_sck(sck_c), .spi_mosi(mosi_c),
        .spi_cs_n(cs_c), .spi_miso(miso_c), .dbg_state(dbg_c));

    // Slave models: MISO word loaded on cs fall, shifted on SCK fall; MOSI
    // captured on SCK rise and required stable the cycle before and after.
    logic [7:0] ret_a = 8'h5E, mret_a = 8'h00, mon_a = 8'h00;
    int         rise_a = 0, cslow_a = 0, dcnt_a = 0, win_a = 0;
    logic       psck_a = 1'b0, pcs_a = 1'b1, pmosi_a = 1'b0;
    always @(negedge clk) begin
        if (cs_a == 1'b0 && pcs_a == 1'b1) begin
            mret_a = ret_a;
            miso_a = mret_a[7];
        end
        if (sck_a && !psck_a) begin
            rise_a++;
            mon_a = {mon_a[6:0], mosi_a};
            if (mosi_a !== pmosi_a) win_a++;
        end
        if (!sck_a && psck_a) begin
            if (pmosi_a !== mon_a[0]) win_a++;
            mret_a = {mret_a[6:0], 1'b0};
            miso_a = mret_a[7];
        end
        if (cs_a == 1'b0) cslow_a++;
        if (done_a) dcnt_a++;
        psck_a = sck_a; pcs_a = cs_a; pmosi_a = mosi_a;
    end

    logic [7:0] ret_b = 8'h00, mret_b = 8'h00, mon_b = 8'h00;
    int         rise_b = 0, cslow_b = 0, dcnt_b = 0, win_b = 0;
    logic       psck_b = 1'b0, pcs_b = 1'b1, pmosi_b = 1'b0;
    always @(negedge clk) begin
        if (cs_b == 1'b0 && pcs_b == 1'b1) begin
            mret_b = ret_b;
            miso_b = mret_b[7];
        end
        if (sck_b && !psck_b) begin
            rise_b++;
            mon_b = {mon_b[6:0], mosi_b};
            if (mosi_b !== pmosi_b) win_b++;
        end
        if (!sck_b && psck_b) begin
            if (pmosi_b !== mon_b[0]) win_b++;
            mret_b = {mret_b[6:0], 1'b0};
            miso_b = mret_b[7];
        end
        if (cs_b == 1'b0) cslow_b++;
        if (done_b) dcnt_b++;
        psck_b = sck_b; pcs_b = cs_b; pmosi_b = mosi_b;
    end

    logic [15:0] ret_c = 16'hB00F, mret_c = 16'h0000, mon_c = 16'h0000;
    int          rise_c = 0, cslow_c = 0, dcnt_c = 0, per_c = 0, ncyc_c = 0, last_rise_c = 0;
    logic        psck_c = 1'b0, pcs_c = 1'b1;
    always @(negedge clk) begin
        ncyc_c++;
        if (cs_c == 1'b0 && pcs_c == 1'b1) begin
            mret_c = ret_c;
            miso_c = mret_c[15];
        end
        if (sck_c && !psck_c) begin
            if (rise_c > 0 && (ncyc_c - last_rise_c) != 2) per_c++;
            last_rise_c = ncyc_c;
            rise_c++;
            mon_c = {mon_c[14:0], mosi_c};
        end
        if (!sck_c && psck_c) begin
            mret_c = {mret_c[14:0], 1'b0};
            miso_c = mret_c[15];
        end
        if (cs_c == 1'b0) cslow_c++;
        if (done_c) dcnt_c++;
        psck_c = sck_c; pcs_c = cs_c;
    end

    // Returns in the done cycle; cyc counts negedges from the call.
    task automatic wait_done(input int which, output int cyc);
        logic d;
        cyc = 0;
        d   = 1'b0;
        while (!d && cyc < LIMIT) begin
            @(negedge clk); #1;
            cyc++;
            d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end
        if (!d) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: dut %0d saw no done after %0d cycles", which, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] ret;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[4];

    // One host transfer on dut_b; called in an idle cycle at negedge+1.
    task automatic xfer_b(input vec_t v);
        int cyc, r0, c0, d0, w0;
        r0 = rise_b; c0 = cslow_b; d0 = dcnt_b; w0 = win_b;
        ret_b = v.ret;
        check("b_ready_before", ready_b, 1);
        start_b = 1'b1;
        tx_b    = v.tx;
        @(posedge clk); #1;
        start_b = 1'b0;
        tx_b    = ~v.tx;
        wait_done(1, cyc);
        check("b_done_latency", cyc, xfer_cycles(8, 2) + 1);
        check("b_rx_data", rx_b, v.exp_rx);
        check("b_mosi_word", mon_b, v.exp_mosi);
        check("b_rises", rise_b - r0, 8);
        check("b_cs_low", cslow_b - c0, xfer_cycles(8, 2));
        check("b_window", win_b - w0, 0);
        check("b_ready_at_done", ready_b, 0);
        @(negedge clk); #1;
        check("b_ready_done_p1", ready_b, 0);
        @(negedge clk); #1;
        check("b_ready_done_p2", ready_b, 1);
        check("b_mosi_idle", mosi_b, 0);
        check("b_done_count", dcnt_b - d0, 1);
        check("b_rx_hold", rx_b, v.exp_rx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, n, r0, c0, d0, w0;
        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h96, 8'h81, 8'h96, 8'h81};

        #1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(negedge clk); #1;
        check("rst_a_cs", cs_a, 1);
        check("rst_a_sck", sck_a, 0);
        check("rst_a_mosi", mosi_a, 0);
        check("rst_a_done", done_a, 0);
        check("rst_a_rx", rx_a, 0);
        check("rst_a_ready", ready_a, 0);
        check("rst_a_state", dbg_a, IDLE);
        check("rst_b_ready", ready_b, 1);
        check("rst_b_cs", cs_b, 1);
        check("rst_c_ready", ready_c, 1);
        check("rst_c_sck", sck_c, 0);
        @(negedge clk); #1;
        rst_b = 1'b0; rst_c = 1'b0;

        // Auto-load of DEFAULT_GAIN right after reset release.
        r0 = rise_a; c0 = cslow_a; d0 = dcnt_a; w0 = win_a;
        rst_a = 1'b0;
        wait_done(0, cyc);
        check("a_done_latency", cyc, xfer_cycles(8, 2) + 1);
        check("a_mosi_word", mon_a, 8'h11);
        check("a_rises", rise_a - r0, 8);
        check("a_cs_low", cslow_a - c0, 36);
        check("a_rx_data", rx_a, 8'h5E);
        check("a_window", win_a - w0, 0);
        check("a_ready_at_done", ready_a, 0);
        @(negedge clk); #1;
        check("a_ready_done_p1", ready_a, 0);
        @(negedge clk); #1;
        check("a_ready_done_p2", ready_a, 1);
        check("a_done_count", dcnt_a - d0, 1);

        // Reset at the 5th SCK rise of an auto-load, then restart on release.
        rst_a = 1'b1;
        @(negedge clk); #1;
        r0 = rise_a;
        rst_a = 1'b0;
        n = 0;
        while ((rise_a - r0) < 5 && n < LIMIT) begin
            @(negedge clk); #1;
            n++;
        end
        check("a_reached_rise5", rise_a - r0, 5);
        d0 = dcnt_a;
        rst_a = 1'b1;
        #1;
        check("a_midrst_cs", cs_a, 1);
        check("a_midrst_sck", sck_a, 0);
        check("a_midrst_mosi", mosi_a, 0);
        check("a_midrst_rx", rx_a, 0);
        check("a_midrst_ready", ready_a, 0);
        repeat (3) @(negedge clk);
        #1;
        check("a_midrst_no_done", dcnt_a - d0, 0);
        ret_a = 8'hC5;
        r0 = rise_a; c0 = cslow_a;
        rst_a = 1'b0;
        wait_done(0, cyc);
        check("a_restart_latency", cyc, xfer_cycles(8, 2) + 1);
        check("a_restart_word", mon_a, 8'h11);
        check("a_restart_rises", rise_a - r0, 8);
        check("a_restart_rx", rx_a, 8'hC5);
        check("a_restart_done_count", dcnt_a - d0, 1);

        // Table-driven host transfers on dut_b.
        for (int i = 0; i < 4; i++) begin
            xfer_b(vecs[i]);
        end

        // start held high: back-to-back transfers with the minimum cs-high gap.
        d0 = dcnt_b;
        ret_b   = 8'h96;
        start_b = 1'b1;
        tx_b    = 8'h01;
        wait_done(1, cyc);
        check("b2b_first_latency", cyc, xfer_cycles(8, 2) + 1);
        check("b2b_first_word", mon_b, 8'h01);
        check("b2b_first_rx", rx_b, 8'h96);
        ret_b = 8'h69;
        tx_b  = 8'hFF;
        n = 0;
        while (cs_b === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk); #1;
        end
        // Gap covers the done cycle, the rest of GAP, and the accepting IDLE cycle.
        check("b2b_cs_high_gap", n, 3);
        // Already one cycle into the transfer, so done is one count earlier.
        wait_done(1, cyc);
        start_b = 1'b0;
        check("b2b_second_latency", cyc, xfer_cycles(8, 2));
        check("b2b_second_word", mon_b, 8'hFF);
        check("b2b_second_rx", rx_b, 8'h69);
        repeat (6) @(negedge clk);
        #1;
        check("b2b_done_count", dcnt_b - d0, 2);
        check("b2b_idle_cs", cs_b, 1);

        // tx_data and start scrambled while busy; start pulsed again in GAP.
        d0 = dcnt_b;
        ret_b   = 8'h3C;
        start_b = 1'b1;
        tx_b    = 8'h5A;
        @(posedge clk); #1;
        n = 0;
        while (!done_b && n < LIMIT) begin
            tx_b    = 8'($urandom_range(0, 255));
            start_b = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            n++;
        end
        start_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b0;
        check("scr_word", mon_b, 8'h5A);
        check("scr_rx", rx_b, 8'h3C);
        repeat (6) @(negedge clk);
        #1;
        check("scr_done_count", dcnt_b - d0, 1);
        check("scr_gap_start_ignored", cs_b, 1);

        // DIV = 1, 16-bit word.
        r0 = rise_c; c0 = cslow_c; d0 = dcnt_c; w0 = per_c;
        start_c = 1'b1;
        tx_c    = 16'h8001;
        @(posedge clk); #1;
        start_c = 1'b0;
        tx_c    = 16'h0000;
        wait_done(2, cyc);
        check("c_done_latency", cyc, 35);
        check("c_mosi_word", mon_c, 16'h8001);
        check("c_first_bit", mon_c[15], 1);
        check("c_last_bit", mon_c[0], 1);
        check("c_rises", rise_c - r0, 16);
        check("c_cs_low", cslow_c - c0, 34);
        check("c_sck_period", per_c - w0, 0);
        check("c_rx_data", rx_c, 16'hB00F);
        check("c_ready_at_done", ready_c, 0);
        @(negedge clk); #1;
        check("c_ready_done_p1", ready_c, 1);
        check("c_done_count", dcnt_c - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
